// File: rtl/program_sequencer.sv
// Program sequencer: a loadable instruction memory that issues one word per start/busy
// handshake, waits for the core to drain the last word, then reports done with cycle/stall stats.
module program_sequencer #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned CNT_WIDTH   = 32,
  localparam int unsigned ADDR_W     = $clog2(DEPTH),
  localparam int unsigned PC_W       = ADDR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   loadEn,
  input  logic [ADDR_W-1:0]      loadAddr,
  input  logic [INSTR_WIDTH-1:0] loadData,
  input  logic [PC_W-1:0]        programLength,
  input  logic                   run,
  input  logic                   stepMode,
  input  logic                   stepReq,
  input  logic                   abort,
  input  logic                   busy,
  output logic [INSTR_WIDTH-1:0] instructionOut,
  output logic                   start,
  output logic [PC_W-1:0]        programCounter,
  output logic                   running,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   cycleCount,
  output logic [CNT_WIDTH-1:0]   stallCount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [PC_W-1:0] DEPTH_L = PC_W'(DEPTH);

  state_e                 state_q;
  logic [PC_W-1:0]        pc_q;
  logic [PC_W-1:0]        len_q;
  logic [CNT_WIDTH-1:0]   cyc_q;
  logic [CNT_WIDTH-1:0]   stall_q;
  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

  logic                 idle_like;
  logic                 issue_ok;
  logic [PC_W-1:0]      len_d;
  logic [CNT_WIDTH-1:0] cyc_d;
  logic [CNT_WIDTH-1:0] stall_d;

  // Handshake and saturating counter increments
  always_comb begin
    idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    issue_ok  = stepMode ? stepReq : 1'b1;
    start     = (state_q == S_ISSUE) && issue_ok && !busy && !abort;
    len_d     = (programLength > DEPTH_L) ? DEPTH_L : programLength;
    cyc_d     = (cyc_q == '1) ? cyc_q : cyc_q + CNT_WIDTH'(1);
    stall_d   = (stall_q == '1) ? stall_q : stall_q + CNT_WIDTH'(1);
  end

  // Program memory is deliberately not reset so contents survive a core reset
  always_ff @(posedge clk) begin
    if (reset && loadEn && idle_like) begin
      mem_q[loadAddr] <= loadData;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      cyc_q   <= '0;
      stall_q <= '0;
    end else if (abort) begin
      // Counters hold so the aborted run can still be inspected
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (run) begin
            pc_q    <= '0;
            cyc_q   <= '0;
            stall_q <= '0;
            len_q   <= len_d;
            state_q <= (len_d != '0) ? S_ISSUE : S_DONE;
          end
        end
        S_ISSUE: begin
          cyc_q <= cyc_d;
          if (issue_ok && busy) begin
            stall_q <= stall_d;
          end
          if (start) begin
            pc_q <= pc_q + PC_W'(1);
            if (pc_q == len_q - PC_W'(1)) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          cyc_q <= cyc_d;
          if (!busy) begin
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instructionOut = mem_q[pc_q[ADDR_W-1:0]];
  assign programCounter = pc_q;
  assign running        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign cycleCount     = cyc_q;
  assign stallCount     = stall_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: free-run, busy stalls, zero length, stepping,
// abort, mid-run reset, length clamping and counter saturation.
module tb_program_sequencer;

  localparam int unsigned IW   = 32;
  localparam int unsigned DEP  = 16;
  localparam int unsigned CW   = 6;
  localparam int unsigned AW   = $clog2(DEP);
  localparam int unsigned PCW  = AW + 1;

  logic           clk = 1'b0;
  logic           reset, loadEn, run, stepMode, stepReq, abort, busy;
  logic [AW-1:0]  loadAddr;
  logic [IW-1:0]  loadData;
  logic [PCW-1:0] programLength;
  logic [IW-1:0]  instructionOut;
  logic           start, running, done;
  logic [PCW-1:0] programCounter;
  logic [CW-1:0]  cycleCount, stallCount;

  int checks = 0;
  int errors = 0;

  program_sequencer #(.INSTR_WIDTH(IW), .DEPTH(DEP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData),
    .programLength(programLength), .run(run), .stepMode(stepMode), .stepReq(stepReq),
    .abort(abort), .busy(busy), .instructionOut(instructionOut), .start(start),
    .programCounter(programCounter), .running(running), .done(done),
    .cycleCount(cycleCount), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input logic [IW-1:0] data);
    loadEn = 1'b1; loadAddr = AW'(addr); loadData = data;
    tick();
    loadEn = 1'b0;
  endtask

  task automatic launch(input int len);
    programLength = PCW'(len); run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  initial begin
    reset = 1'b0; loadEn = 1'b0; run = 1'b0; stepMode = 1'b0; stepReq = 1'b0;
    abort = 1'b0; busy = 1'b0; loadAddr = '0; loadData = '0; programLength = '0;
    tick(); tick();
    #1;
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pc", 64'(programCounter), 64'd0);
    chk("rst_cyc", 64'(cycleCount), 64'd0);
    chk("rst_stall", 64'(stallCount), 64'd0);
    reset = 1'b1;
    tick();

    // Free run of four words with the core always ready
    for (int i = 0; i < 4; i++) load(i, 32'hA000_0000 + 32'(i));
    launch(4);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("free_start", 64'(start), 64'd1);
      chk("free_instr", 64'(instructionOut), 64'hA000_0000 + 64'(i));
      chk("free_pc", 64'(programCounter), 64'(i));
      tick();
    end
    #1;
    chk("free_drain_start", 64'(start), 64'd0);
    chk("free_drain_running", 64'(running), 64'd1);
    chk("free_drain_done", 64'(done), 64'd0);
    tick();
    chk("free_done", 64'(done), 64'd1);
    chk("free_running", 64'(running), 64'd0);
    chk("free_cyc", 64'(cycleCount), 64'd5);
    chk("free_stall", 64'(stallCount), 64'd0);
    chk("free_pc_end", 64'(programCounter), 64'd4);

    // Core busy for two cycles after every issue
    launch(4);
    for (int k = 0; k < 4; k++) begin
      busy = 1'b0; #1;
      chk("busy_issue", 64'(start), 64'd1);
      chk("busy_instr", 64'(instructionOut), 64'hA000_0000 + 64'(k));
      tick();
      busy = 1'b1; #1;
      chk("busy_hold1", 64'(start), 64'd0);
      tick();
      #1;
      chk("busy_hold2", 64'(start), 64'd0);
      chk("busy_not_done", 64'(done), 64'd0);
      tick();
    end
    busy = 1'b0; #1;
    chk("busy_drain_running", 64'(running), 64'd1);
    chk("busy_drain_done", 64'(done), 64'd0);
    tick();
    chk("busy_done", 64'(done), 64'd1);
    chk("busy_stall", 64'(stallCount), 64'd6);
    chk("busy_cyc", 64'(cycleCount), 64'd13);

    // Zero-length program goes straight to DONE
    launch(0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_start", 64'(start), 64'd0);
    chk("zero_running", 64'(running), 64'd0);
    chk("zero_cyc", 64'(cycleCount), 64'd0);
    chk("zero_stall", 64'(stallCount), 64'd0);

    // Single-step: requests at run-relative cycles 2, 5 and 9
    stepMode = 1'b1;
    launch(4);
    for (int c = 0; c < 11; c++) begin
      stepReq = (c == 2 || c == 5 || c == 9); #1;
      chk("step_start", 64'(start), 64'(stepReq));
      tick();
    end
    stepReq = 1'b0;
    chk("step_pc", 64'(programCounter), 64'd3);
    chk("step_running", 64'(running), 64'd1);
    stepReq = 1'b1; #1;
    chk("step_last", 64'(start), 64'd1);
    tick();
    stepReq = 1'b0;
    tick();
    chk("step_done", 64'(done), 64'd1);
    chk("step_cyc", 64'(cycleCount), 64'd13);
    stepMode = 1'b0;

    // Abort during ISSUE at pc=2, then reload and restart
    launch(4);
    tick(); tick();
    abort = 1'b1; #1;
    chk("abort_pc_before", 64'(programCounter), 64'd2);
    chk("abort_start_forced", 64'(start), 64'd0);
    tick();
    abort = 1'b0;
    chk("abort_pc", 64'(programCounter), 64'd0);
    chk("abort_running", 64'(running), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_start", 64'(start), 64'd0);
    chk("abort_cyc_held", 64'(cycleCount), 64'd2);
    load(1, 32'h5555_0001);
    launch(2);
    #1;
    chk("rerun_instr0", 64'(instructionOut), 64'hA000_0000);
    tick();
    chk("rerun_instr1", 64'(instructionOut), 64'h5555_0001);
    chk("rerun_start1", 64'(start), 64'd1);
    tick(); tick();
    chk("rerun_done", 64'(done), 64'd1);

    // Reset in DRAIN clears state but not memory
    launch(1);
    tick();
    busy = 1'b1; #1;
    chk("rst_mid_running", 64'(running), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1; busy = 1'b0;
    chk("rst_mid_running0", 64'(running), 64'd0);
    chk("rst_mid_done0", 64'(done), 64'd0);
    chk("rst_mid_pc0", 64'(programCounter), 64'd0);
    chk("rst_mid_cyc0", 64'(cycleCount), 64'd0);
    chk("rst_mid_start0", 64'(start), 64'd0);
    launch(2);
    chk("mem_kept0", 64'(instructionOut), 64'hA000_0000);
    tick();
    chk("mem_kept1", 64'(instructionOut), 64'h5555_0001);
    tick(); tick();
    chk("mem_kept_done", 64'(done), 64'd1);

    // Length above DEPTH is clamped to DEPTH
    launch(31);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("clamp_start", 64'(start), 64'd1);
      chk("clamp_pc", 64'(programCounter), 64'(i));
      tick();
    end
    #1;
    chk("clamp_drain_start", 64'(start), 64'd0);
    tick();
    chk("clamp_done", 64'(done), 64'd1);
    chk("clamp_pc_end", 64'(programCounter), 64'd16);
    chk("clamp_cyc", 64'(cycleCount), 64'd17);

    // Counters saturate at all-ones (6-bit -> 63)
    busy = 1'b1;
    launch(1);
    for (int i = 0; i < 70; i++) tick();
    chk("sat_stall", 64'(stallCount), 64'd63);
    chk("sat_cyc", 64'(cycleCount), 64'd63);
    busy = 1'b0; #1;
    chk("sat_start", 64'(start), 64'd1);
    tick(); tick();
    chk("sat_done", 64'(done), 64'd1);
    chk("sat_cyc_hold", 64'(cycleCount), 64'd63);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
